// File: rtl/sdr_reply_send.sv
// -----------------------------------------------------------------------------
// sdr_reply_send
//
// Builds the fixed-length UDP reply payload for the port-1024 command parser.
// Level-held requests from the parser (erase_done > send_more > discovery_reply)
// are taken in IDLE and acknowledged with a one-cycle pulse. The block then
// arbitrates for the UDP transmit path and streams the payload one byte per
// accepted cycle.
//
// Optional feature macro: SDR_REPLY_STATUS_EN
//   When defined, adds input busy_status[7:0]. A discovery reply then reports
//   type 0x03 ("board in use") whenever busy_status != 0, and byte 13 carries
//   busy_status. When undefined, byte 4 is the plain type and byte 13 is 0x00.
//
// Ports
//   rx_clock, reset_n        clock (rising edge), asynchronous active-low reset
//   discovery_reply          level request, held until discovery_ACK
//   erase_done               level request, held until erase_ACK_out
//   send_more                level request, held until send_more_ACK
//   sequence_number[31:0]    captured with the request
//   local_mac[47:0]          captured with the request
//   board_id, code_version   sent live in bytes 12 and 11
//   udp_tx_grant             transmit path granted; dropping it mid-SEND aborts
//   udp_tx_ready             sink accepts the presented byte this cycle
//   udp_tx_request           request for the transmit path
//   udp_tx_data/valid/last   payload byte stream
//   discovery_ACK, send_more_ACK, erase_ACK_out   one-cycle request pulses
//   sending_sync             high from capture until last byte accepted/abort
//   timeout_flag             sticky grant-timeout indicator (reset clears it)
//   fsm_state[1:0]           debug view of the FSM (0 IDLE,1 REQ,2 SEND,3 GAP)
//
// Byte handshake: a byte transfers on a rising edge where udp_tx_valid and
// udp_tx_ready are both 1. While valid is high and ready is low, udp_tx_data
// and udp_tx_last hold their values. valid never depends on ready.
// -----------------------------------------------------------------------------
module sdr_reply_send #(
  parameter int PAYLOAD_LEN   = 60,
  parameter int GRANT_TIMEOUT = 1024
) (
  input  logic        rx_clock,
  input  logic        reset_n,
  input  logic        discovery_reply,
  input  logic        erase_done,
  input  logic        send_more,
  input  logic [31:0] sequence_number,
  input  logic [47:0] local_mac,
  input  logic [7:0]  board_id,
  input  logic [7:0]  code_version,
`ifdef SDR_REPLY_STATUS_EN
  input  logic [7:0]  busy_status,
`endif
  input  logic        udp_tx_grant,
  input  logic        udp_tx_ready,
  output logic        udp_tx_request,
  output logic [7:0]  udp_tx_data,
  output logic        udp_tx_valid,
  output logic        udp_tx_last,
  output logic        discovery_ACK,
  output logic        send_more_ACK,
  output logic        erase_ACK_out,
  output logic        sending_sync,
  output logic        timeout_flag,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int              TW       = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [7:0]      LAST_IDX = 8'(PAYLOAD_LEN - 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(GRANT_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [31:0]   seq_q, seq_nxt;
  logic [47:0]   mac_q, mac_nxt;
  logic [7:0]    type_q, type_nxt;
  logic [2:0]    ack_q, ack_nxt;       // {erase, send_more, discovery}
  logic          timeout_q, timeout_nxt;
  logic          any_req;
  logic [7:0]    type_byte;
  logic [7:0]    status_byte;
  logic [7:0]    tx_byte;

  assign any_req = erase_done | send_more | discovery_reply;

  // State and datapath registers
  always_ff @(posedge rx_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      tcnt      <= '0;
      seq_q     <= 32'd0;
      mac_q     <= 48'd0;
      type_q    <= 8'd0;
      ack_q     <= 3'b000;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      tcnt      <= tcnt_nxt;
      seq_q     <= seq_nxt;
      mac_q     <= mac_nxt;
      type_q    <= type_nxt;
      ack_q     <= ack_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tcnt_nxt    = tcnt;
    seq_nxt     = seq_q;
    mac_nxt     = mac_q;
    type_nxt    = type_q;
    ack_nxt     = 3'b000;
    timeout_nxt = timeout_q;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          seq_nxt   = sequence_number;
          mac_nxt   = local_mac;
          tcnt_nxt  = '0;
          state_nxt = ST_REQ;
          if (erase_done) begin
            type_nxt = 8'd3;
            ack_nxt  = 3'b100;
          end else if (send_more) begin
            type_nxt = 8'd4;
            ack_nxt  = 3'b010;
          end else begin
            type_nxt = 8'd2;
            ack_nxt  = 3'b001;
          end
        end
      end
      ST_REQ: begin
        if (udp_tx_grant) begin
          cnt_nxt   = 8'd0;
          state_nxt = ST_SEND;
        end else if (tcnt == TO_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_GAP;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      ST_SEND: begin
        // Losing the grant wins over a simultaneous byte acceptance.
        if (!udp_tx_grant) begin
          state_nxt = ST_GAP;
        end else if (udp_tx_ready) begin
          if (cnt == LAST_IDX) begin
            state_nxt = ST_GAP;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef SDR_REPLY_STATUS_EN
  assign type_byte   = (type_q == 8'd2 && busy_status != 8'd0) ? 8'h03 : type_q;
  assign status_byte = busy_status;
`else
  assign type_byte   = type_q;
  assign status_byte = 8'h00;
`endif

  // Payload byte map indexed by the byte counter
  always_comb begin
    tx_byte = 8'h00;
    case (cnt)
      8'd0:    tx_byte = seq_q[31:24];
      8'd1:    tx_byte = seq_q[23:16];
      8'd2:    tx_byte = seq_q[15:8];
      8'd3:    tx_byte = seq_q[7:0];
      8'd4:    tx_byte = type_byte;
      8'd5:    tx_byte = mac_q[47:40];
      8'd6:    tx_byte = mac_q[39:32];
      8'd7:    tx_byte = mac_q[31:24];
      8'd8:    tx_byte = mac_q[23:16];
      8'd9:    tx_byte = mac_q[15:8];
      8'd10:   tx_byte = mac_q[7:0];
      8'd11:   tx_byte = code_version;
      8'd12:   tx_byte = board_id;
      8'd13:   tx_byte = status_byte;
      default: tx_byte = 8'h00;
    endcase
  end

  // Outputs decode from registered state so reset clears them at once.
  assign udp_tx_request = (state == ST_REQ) || (state == ST_SEND);
  assign sending_sync   = (state == ST_REQ) || (state == ST_SEND);
  assign udp_tx_valid   = (state == ST_SEND);
  assign udp_tx_last    = (state == ST_SEND) && (cnt == LAST_IDX);
  assign udp_tx_data    = (state == ST_SEND) ? tx_byte : 8'h00;
  assign erase_ACK_out  = ack_q[2];
  assign send_more_ACK  = ack_q[1];
  assign discovery_ACK  = ack_q[0];
  assign timeout_flag   = timeout_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_sdr_reply_send.sv
// -----------------------------------------------------------------------------
// tb_sdr_reply_send
//
// Directed bench for sdr_reply_send: discovery, request priority, backpressure,
// grant timeout, mid-packet grant loss and asynchronous reset. Expected payload
// bytes come from a small byte-map model pushed into exp_q.
// -----------------------------------------------------------------------------
module tb_sdr_reply_send;
  localparam int PAYLOAD_LEN   = 60;
  localparam int GRANT_TIMEOUT = 1024;

  // Clock / reset
  logic rx_clock = 1'b0;
  logic reset_n  = 1'b0;
  always #5 rx_clock = ~rx_clock;

  logic        discovery_reply = 1'b0;
  logic        erase_done      = 1'b0;
  logic        send_more       = 1'b0;
  logic [31:0] sequence_number = 32'd0;
  logic [47:0] local_mac       = 48'd0;
  logic [7:0]  board_id        = 8'h06;
  logic [7:0]  code_version    = 8'h15;
  logic        udp_tx_grant    = 1'b0;
  logic        udp_tx_ready    = 1'b0;
`ifdef SDR_REPLY_STATUS_EN
  logic [7:0]  busy_status     = 8'h00;
`endif
  logic        udp_tx_request;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_valid;
  logic        udp_tx_last;
  logic        discovery_ACK;
  logic        send_more_ACK;
  logic        erase_ACK_out;
  logic        sending_sync;
  logic        timeout_flag;
  logic [1:0]  fsm_state;

  sdr_reply_send #(
    .PAYLOAD_LEN   (PAYLOAD_LEN),
    .GRANT_TIMEOUT (GRANT_TIMEOUT)
  ) dut (
    .rx_clock        (rx_clock),
    .reset_n         (reset_n),
    .discovery_reply (discovery_reply),
    .erase_done      (erase_done),
    .send_more       (send_more),
    .sequence_number (sequence_number),
    .local_mac       (local_mac),
    .board_id        (board_id),
    .code_version    (code_version),
`ifdef SDR_REPLY_STATUS_EN
    .busy_status     (busy_status),
`endif
    .udp_tx_grant    (udp_tx_grant),
    .udp_tx_ready    (udp_tx_ready),
    .udp_tx_request  (udp_tx_request),
    .udp_tx_data     (udp_tx_data),
    .udp_tx_valid    (udp_tx_valid),
    .udp_tx_last     (udp_tx_last),
    .discovery_ACK   (discovery_ACK),
    .send_more_ACK   (send_more_ACK),
    .erase_ACK_out   (erase_ACK_out),
    .sending_sync    (sending_sync),
    .timeout_flag    (timeout_flag),
    .fsm_state       (fsm_state)
  );

  // Scoreboard
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rx_clock);
    #1;
  endtask

  // Reference byte map of one reply
  task automatic load_expected(input logic [31:0] seq, input logic [47:0] mac,
                               input logic [7:0] typ);
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < PAYLOAD_LEN; i++) begin
      b = 8'h00;
      if (i < 4)        b = seq[8*(3-i) +: 8];
      else if (i == 4) begin
        b = typ;
`ifdef SDR_REPLY_STATUS_EN
        if (typ == 8'd2 && busy_status != 8'd0) b = 8'h03;
`endif
      end
      else if (i < 11)  b = mac[8*(10-i) +: 8];
      else if (i == 11) b = code_version;
      else if (i == 12) b = board_id;
`ifdef SDR_REPLY_STATUS_EN
      else if (i == 13) b = busy_status;
`endif
      exp_q.push_back(b);
    end
  endtask

  // One reply. which: 0 discovery, 1 send_more, 2 erase.
  // abort_kind: 0 none, 1 grant drop at byte abort_at, 2 reset at byte abort_at.
  task automatic run_reply(input int which, input logic [7:0] typ, input int gdelay,
                           input int rmode, input int abort_kind, input int abort_at,
                           input string name);
    logic [2:0] acks;
    logic [7:0] exp_b;
    logic [7:0] prev_d;
    logic       tf_before;
    int         bound, p, acc, cyc;
    bit         done, have_prev, prev_acc, stray;
    bound = 0; p = 0; acc = 0; cyc = 0;
    done = 0; have_prev = 0; prev_acc = 0; stray = 0; prev_d = 8'h00;
    acks = {erase_ACK_out, send_more_ACK, discovery_ACK};
    while (acks == 3'b000 && bound < 50) begin
      tick();
      bound++;
      acks = {erase_ACK_out, send_more_ACK, discovery_ACK};
    end
    check({name, " ack"}, acks, 3'b001 << which);
    check({name, " req"}, udp_tx_request, 1);
    check({name, " sync"}, sending_sync, 1);
    check({name, " state_req"}, fsm_state, 2'd1);
    load_expected(sequence_number, local_mac, typ);
    case (which)
      0: discovery_reply = 1'b0;
      1: send_more = 1'b0;
      default: erase_done = 1'b0;
    endcase
    // Captured fields must stay frozen for the rest of the reply.
    sequence_number = $urandom;
    local_mac = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    tick();
    check({name, " ack_pulse"}, {erase_ACK_out, send_more_ACK, discovery_ACK}, 3'b000);
    for (int i = 1; i < gdelay; i++) tick();
    check({name, " no_valid_before_grant"}, udp_tx_valid, 0);
    udp_tx_grant = 1'b1;
    tick();
    check({name, " first_valid"}, udp_tx_valid, 1);
    tf_before = timeout_flag;
    while (!done && cyc < 1000) begin
      if (abort_kind != 0 && acc == abort_at) break;
      udp_tx_ready = (rmode == 0) ? 1'b1 : ((p % 4 == 0) || (p % 4 == 3));
      p++;
      if (erase_ACK_out | send_more_ACK | discovery_ACK) stray = 1;
      if (have_prev && !prev_acc) check({name, " hold"}, udp_tx_data, prev_d);
      if (udp_tx_valid && udp_tx_ready) begin
        if (exp_q.size() == 0) begin
          check({name, " overrun"}, 1, 0);
          done = 1;
        end else begin
          exp_b = exp_q.pop_front();
          check($sformatf("%s byte%0d", name, acc), udp_tx_data, exp_b);
          check($sformatf("%s last%0d", name, acc), udp_tx_last, exp_q.size() == 0);
          acc++;
          done = (exp_q.size() == 0);
        end
      end
      have_prev = udp_tx_valid;
      prev_acc  = udp_tx_ready;
      prev_d    = udp_tx_data;
      tick();
      cyc++;
    end
    check({name, " no_ack_while_busy"}, stray, 0);
    if (abort_kind == 0) begin
      check({name, " done"}, done, 1);
      check({name, " count"}, acc, PAYLOAD_LEN);
      check({name, " end_valid"}, udp_tx_valid, 0);
      check({name, " end_last"}, udp_tx_last, 0);
      check({name, " end_req"}, udp_tx_request, 0);
      check({name, " end_sync"}, sending_sync, 0);
      check({name, " state_gap"}, fsm_state, 2'd3);
      udp_tx_ready = 1'b0;
      udp_tx_grant = 1'b0;
      tick();
      check({name, " state_idle"}, fsm_state, 2'd0);
      check({name, " sync_idle"}, sending_sync, 0);
    end else if (abort_kind == 1) begin
      check({name, " reached"}, acc, abort_at);
      udp_tx_grant = 1'b0;
      tick();
      check({name, " ab_valid"}, udp_tx_valid, 0);
      check({name, " ab_req"}, udp_tx_request, 0);
      check({name, " ab_sync"}, sending_sync, 0);
      check({name, " ab_data"}, udp_tx_data, 0);
      check({name, " ab_state_gap"}, fsm_state, 2'd3);
      check({name, " ab_timeout_kept"}, timeout_flag, tf_before);
      udp_tx_ready = 1'b0;
      tick();
      check({name, " ab_state_idle"}, fsm_state, 2'd0);
    end else begin
      check({name, " reached"}, acc, abort_at);
      #2;
      reset_n = 1'b0;
      #1;
      check({name, " rst_valid"}, udp_tx_valid, 0);
      check({name, " rst_req"}, udp_tx_request, 0);
      check({name, " rst_sync"}, sending_sync, 0);
      check({name, " rst_data"}, udp_tx_data, 0);
      check({name, " rst_state"}, fsm_state, 2'd0);
      check({name, " rst_timeout"}, timeout_flag, 0);
      udp_tx_grant = 1'b0;
      udp_tx_ready = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst valid", udp_tx_valid, 0);
    check("rst req", udp_tx_request, 0);
    check("rst sync", sending_sync, 0);
    check("rst acks", {erase_ACK_out, send_more_ACK, discovery_ACK}, 3'b000);
    check("rst timeout", timeout_flag, 0);
    check("rst state", fsm_state, 2'd0);
    check("rst data", udp_tx_data, 0);
    reset_n = 1'b1;
    tick();

    // Discovery with the reference header
    sequence_number = 32'h0102_0304;
    local_mac       = 48'h001C_C0A2_13DD;
    discovery_reply = 1'b1;
    run_reply(0, 8'd2, 3, 0, 0, 0, "disc");

    // Priority: erase, then send_more, then discovery
    sequence_number = 32'hA0B0_C0D0;
    local_mac       = 48'h0200_0000_0001;
    erase_done      = 1'b1;
    send_more       = 1'b1;
    discovery_reply = 1'b1;
    run_reply(2, 8'd3, 1, 0, 0, 0, "prio_erase");
    run_reply(1, 8'd4, 2, 0, 0, 0, "prio_more");
    run_reply(0, 8'd2, 1, 0, 0, 0, "prio_disc");

    // Backpressure with ready pattern 1,0,0,1
    send_more = 1'b1;
    run_reply(1, 8'd4, 2, 1, 0, 0, "bp");

    // Grant timeout
    discovery_reply = 1'b1;
    tick();
    check("to ack", discovery_ACK, 1);
    discovery_reply = 1'b0;
    repeat (GRANT_TIMEOUT - 1) tick();
    check("to req_still", udp_tx_request, 1);
    check("to flag_not_yet", timeout_flag, 0);
    tick();
    check("to req", udp_tx_request, 0);
    check("to sync", sending_sync, 0);
    check("to flag", timeout_flag, 1);
    check("to state_gap", fsm_state, 2'd3);
    tick();
    check("to state_idle", fsm_state, 2'd0);
    send_more = 1'b1;
    run_reply(1, 8'd4, 1, 0, 0, 0, "after_to");
    check("to sticky", timeout_flag, 1);

    // Grant dropped at byte 20
    discovery_reply = 1'b1;
    run_reply(0, 8'd2, 1, 0, 1, 20, "abort");

    // Reset at byte 30, then a fresh reply from byte 0
    discovery_reply = 1'b1;
    run_reply(0, 8'd2, 1, 0, 2, 30, "rst");
    discovery_reply = 1'b1;
    run_reply(0, 8'd2, 2, 0, 0, 0, "fresh");

`ifdef SDR_REPLY_STATUS_EN
    busy_status     = 8'h01;
    discovery_reply = 1'b1;
    run_reply(0, 8'd2, 1, 0, 0, 0, "busy");
    busy_status     = 8'h00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdr_reply_send.md
Name: sdr_reply_send

Overview:
- Downstream companion of the port-1024 command parser.
- Consumes its request strobes (discovery_reply, erase-complete, send-more) and builds the fixed 60-byte UDP reply payload.
- Arbitrates for the UDP transmit path and streams the payload one byte per clock.
- Returns discovery_ACK / send_more_ACK and drives sending_sync, which the parser uses to leave its ST_TX state.

Parameters:
- PAYLOAD_LEN, 60, reply payload length in bytes (legal range 16..255).
- GRANT_TIMEOUT, 1024, cycles to wait for udp_tx_grant before abandoning a reply.

Ports:
- rx_clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- discovery_reply  in  1  level request from parser; held until discovery_ACK.
- erase_done  in  1  level request: EPCS erase finished.
- send_more  in  1  level request: EPCS fifo ready for next block.
- sequence_number  in  32  sequence number captured by parser.
- local_mac  in  48  board MAC.
- board_id  in  8  board type code.
- code_version  in  8  firmware version.
- udp_tx_grant  in  1  transmit path granted to this block.
- udp_tx_ready  in  1  sink accepts a byte this cycle.
- udp_tx_request  out  1  request for the transmit path.
- udp_tx_data  out  8  payload byte.
- udp_tx_valid  out  1  udp_tx_data is valid.
- udp_tx_last  out  1  final payload byte.
- discovery_ACK  out  1  one-cycle pulse: discovery request taken.
- send_more_ACK  out  1  one-cycle pulse: send_more request taken.
- erase_ACK_out  out  1  one-cycle pulse: erase_done request taken.
- sending_sync  out  1  high from request capture until the last byte is accepted or the reply is aborted.
- timeout_flag  out  1  sticky; set on grant timeout; cleared only by reset.

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; captured sequence number, MAC and type 0.
- States: IDLE, REQ, SEND, GAP.
- IDLE:
  - Samples requests with priority erase_done > send_more > discovery_reply.
  - On any request, in the same edge: latches sequence_number and local_mac; sets type = 3 (erase), 4 (send more) or 2 (discovery); pulses the matching ACK for exactly one cycle; sets sending_sync = 1 and udp_tx_request = 1; goes to REQ.
  - Lower-priority requests still asserted are served in later passes.
- REQ:
  - Waits for udp_tx_grant while the timeout counter increments.
  - Grant → counter = 0, go to SEND.
  - Timeout counter reaches GRANT_TIMEOUT-1 without grant → drop udp_tx_request and sending_sync, set timeout_flag, go to GAP.
- SEND:
  - udp_tx_valid = 1.
  - The byte counter advances only on a cycle with udp_tx_ready = 1; if ready is low, data is held stable.
- Byte map (counter index):
  - 0-3: sequence_number MSB first.
  - 4: type.
  - 5-10: MAC MSB first.
  - 11: code_version.
  - 12: board_id.
  - 13..PAYLOAD_LEN-1: 0x00.
- udp_tx_last = 1 when counter = PAYLOAD_LEN-1.
- On an accepted last byte: drop valid, last, request and sending_sync; go to GAP.
- GAP: one idle cycle, then IDLE. This guarantees sending_sync is low for at least 1 cycle between replies.
- Grant deasserted mid-SEND: abort immediately; drop all transmit outputs and sending_sync; go to GAP. timeout_flag is not set.
- Requests arriving outside IDLE are not acknowledged. Because requests are level-held, they are served after GAP.
- Captured fields stay frozen for the whole reply even if the inputs change.
- Asynchronous reset mid-SEND: outputs clear immediately; no partial-packet recovery.
- Latency: request asserted at edge N → ACK and udp_tx_request high after edge N; first byte valid the cycle after grant is sampled.

Optional Feature:
- Macro: SDR_REPLY_STATUS_EN.
- Defined:
  - Adds input busy_status[7:0].
  - For type-2 replies, byte 4 becomes 0x03 when busy_status != 0 (PC sees "board in use").
  - Byte 13 carries busy_status.
- Undefined: the input is absent, byte 4 is the type as above, and byte 13 is 0x00.

Test Plan:
- Discovery: discovery_reply=1, seq=0x01020304, MAC=0x00_1C_C0_A2_13_DD, grant after 3 cycles, ready=1 → discovery_ACK pulses for 1 cycle; 60 bytes emitted: 01 02 03 04 02 00 1C C0 A2 13 DD ver id then zeros; last on byte 59; sending_sync low 1 cycle after last.
- Priority: erase_done, send_more and discovery all high together → three replies of type 3, then 4, then 2, each preceded by its own single ACK pulse and separated by ≥1 cycle of sending_sync low.
- Backpressure: ready toggles 1,0,0,1 continuously → data stable while ready=0; exactly 60 accepted bytes; no duplicated or skipped index.
- Timeout: grant held 0 → after 1024 cycles request and sending_sync fall, timeout_flag=1, block returns to IDLE and serves the next request normally.
- Abort and reset: grant drops at byte 20 → outputs 0 next cycle, GAP then IDLE. Separately, reset_n low at byte 30 → all outputs 0 asynchronously; after release a fresh discovery reply starts at byte 0.
- Optional feature (SDR_REPLY_STATUS_EN defined): busy_status=0x01 with discovery → byte 4 = 0x03, byte 13 = 0x01.
